// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator:
// opcodes and controller states.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift the next dividend
// bit into the remainder, subtract the divisor if it fits.
module div_restoring_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, i_div};

   // A borrow means the divisor did not fit: restore.
   always_comb begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
      if (w_diff[WIDTH]) begin
         o_rem = w_shift[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_calculator.sv
// Handshaked four-function calculator; add/sub/mul finish
// in one cycle, divide iterates one bit per cycle.
module seq_calculator
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   first_num,
   input  logic [WIDTH-1:0]   second_num,
   input  logic [1:0]         operation,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e             r_state;
   state_e             w_next;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_result;
   logic               r_dbz;

   logic [WIDTH-1:0]   w_rem_n;
   logic [WIDTH-1:0]   w_quo_n;
   logic [2*WIDTH-1:0] w_alu;
   logic [2*WIDTH-1:0] w_a;
   logic [2*WIDTH-1:0] w_b;
   logic               w_accept;
   logic               w_is_div;
   logic               w_iterate;
   op_e                w_op;

   assign w_op      = op_e'(operation);
   assign w_a       = {{WIDTH{1'b0}}, first_num};
   assign w_b       = {{WIDTH{1'b0}}, second_num};
   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_is_div  = (w_op == OP_DIV);
   assign w_iterate = w_is_div && (second_num != '0);

   div_restoring_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_rem_n),
      .o_quo (w_quo_n)
   );

   // Divide-by-zero: quotient all ones, remainder = A.
   always_comb begin
      w_alu = '0;
      unique case (w_op)
         OP_ADD: w_alu = w_a + w_b;
         OP_SUB: w_alu = w_b - w_a;
         OP_MUL: w_alu = w_a * w_b;
         OP_DIV: w_alu = {first_num, {WIDTH{1'b1}}};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next = w_iterate ? DIV : DONE;
         DIV:  if (r_cnt == LAST) w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state == IDLE);
      out_valid   = (r_state == DONE);
      result      = r_result;
      div_by_zero = r_dbz;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_dbz    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (w_accept) begin
               r_rem <= '0;
               r_quo <= first_num;
               r_div <= second_num;
               r_cnt <= '0;
               if (!w_iterate) begin
                  r_result <= w_alu;
                  r_dbz    <= w_is_div;
               end
            end
            DIV: begin
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               if (r_cnt == LAST) begin
                  r_result <= {w_rem_n, w_quo_n};
                  r_dbz    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed plus randomized checks of seq_calculator
// against a plain-arithmetic reference model.
module tb_seq_calculator;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   first_num;
   logic [W-1:0]   second_num;
   logic [1:0]     operation;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic           div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_calculator #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .first_num   (first_num),
      .second_num  (second_num),
      .operation   (operation),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input int op, input int a,
                                 input int b,
                                 output logic [15:0] r,
                                 output logic z);
      int v;
      z = 1'b0;
      case (op)
         0: v = a + b;
         1: v = b - a;
         2: v = a * b;
         default: begin
            if (b == 0) begin
               v = a * 256 + 255;
               z = 1'b1;
            end else begin
               v = (a % b) * 256 + (a / b);
            end
         end
      endcase
      r = 16'(v);
   endfunction

   task automatic run(input int op, input int a, input int b,
                      input int hold);
      logic [15:0] exp_r;
      logic        exp_z;
      int          exp_lat;
      int          lat;
      model(op, a, b, exp_r, exp_z);
      exp_lat = (op == 3 && b != 0) ? W + 1 : 1;
      chk("idle_ready", 32'(in_ready), 1);
      in_valid   = 1'b1;
      first_num  = 8'(a);
      second_num = 8'(b);
      operation  = 2'(op);
      out_ready  = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid   = 1'b0;
      first_num  = 8'($urandom);
      second_num = 8'($urandom);
      operation  = 2'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         chk("busy_ready", 32'(in_ready), 0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("result", 32'(result), 32'(exp_r));
      chk("dbz", 32'(div_by_zero), 32'(exp_z));
      for (int i = 0; i < hold; i++) begin
         in_valid   = 1'b1;
         first_num  = 8'($urandom);
         second_num = 8'($urandom);
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_result", 32'(result), 32'(exp_r));
         chk("hold_dbz", 32'(div_by_zero), 32'(exp_z));
         chk("hold_ready", 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("consumed", 32'(out_valid), 0);
      chk("back_idle", 32'(in_ready), 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      first_num  = '0;
      second_num = '0;
      operation  = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_dbz", 32'(div_by_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 200, 100, 0);
      chk("add_const", 32'(result), 32'h012C);
      run(1, 5, 3, 0);
      chk("sub_const", 32'(result), 32'hFFFE);
      run(2, 255, 255, 0);
      chk("mul_const", 32'(result), 32'hFE01);
      run(3, 200, 7, 0);
      chk("div_const", 32'(result), 32'h041C);
      run(3, 13, 0, 0);
      chk("dz_const", 32'(result), 32'h0DFF);
      run(2, 17, 19, 5);
      run(3, 255, 1, 0);
      run(3, 3, 250, 2);

      in_valid   = 1'b1;
      first_num  = 8'd200;
      second_num = 8'd7;
      operation  = 2'd3;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_ready", 32'(in_ready), 1);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_result", 32'(result), 0);
      run(0, 1, 1, 0);
      chk("post_rst_add", 32'(result), 32'h0002);

      for (int k = 0; k < 40; k++) begin
         int op, a, b;
         op = $urandom_range(0, 3);
         a  = $urandom_range(0, 255);
         b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
         run(op, a, b, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, handshaked successor to the team's combinational four-function calculator. It accepts one operand pair plus a 2-bit opcode per transaction over a valid/ready input port and returns a 2×WIDTH-bit result over a valid/ready output port. Add, subtract and multiply complete in one cycle; divide is an iterative restoring divider that returns both quotient and remainder, and flags divide-by-zero. It sits between an operand-issuing controller and a result consumer that may apply backpressure.

## Interface
- WIDTH, 8: operand width in bits; result width is 2*WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand pair and opcode are valid.
- in_ready  out  1  block can accept a transaction.
- first_num  in  WIDTH  operand A, unsigned.
- second_num  in  WIDTH  operand B, unsigned.
- operation  in  2  00 add, 01 sub, 10 mul, 11 div.
- out_valid  out  1  result and flag are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  result word.
- div_by_zero  out  1  qualified by out_valid; set only for div with B==0.

## Operation
- Input handshake: a transaction is accepted on a rising edge where in_valid && in_ready. Operands and opcode are captured in registers at acceptance; the inputs are don't-care afterwards.
- FSM states and transitions:
  - IDLE: in_ready=1. On accept, go to DONE for add/sub/mul, or for div with B==0. Go to DIV for div with B!=0.
  - DIV: in_ready=0. Run exactly WIDTH iterations, then go to DONE.
  - DONE: out_valid=1, in_ready=0. Go to IDLE on out_ready.
- Arithmetic, all mod 2^(2*WIDTH):
  - add: result = A + B, zero-extended.
  - sub: result = B − A, two's complement over 2*WIDTH bits. The order B minus A is fixed.
  - mul: result = A × B, unsigned.
  - div: result[WIDTH-1:0] = A / B (quotient) and result[2*WIDTH-1:WIDTH] = A % B (remainder).
  - div with B==0: quotient = all ones, remainder = A, div_by_zero=1.
- div_by_zero=0 for every other result.
- result and div_by_zero are held stable while out_valid=1 and out_ready=0.
- No new transaction is accepted until the current result is consumed, so at most one transaction is in flight.

## Timing
- Reset (rst_n=0 at an edge):
  - state goes to IDLE, so in_ready=1 in the following cycle.
  - out_valid=0, result=0, div_by_zero=0, iteration counter=0.
- Reset takes priority over every other event. Asserting it mid-DIV or in DONE abandons the transaction and the result is lost.
- Latency from the accept edge to the first cycle with out_valid=1:
  - add, sub, mul, and div with B==0: 1 cycle.
  - div with B!=0: WIDTH+1 cycles.
- Throughput: at most one transaction every 2 cycles (accept, then DONE+consume), when out_ready is held high.
- Simultaneous events:
  - in_valid asserted while in DONE: no accept. in_ready=0 in that state.
  - out_ready asserted while not in DONE: ignored.
- Iteration counter runs 0..WIDTH-1 with no wrap beyond that. DIV exits when the counter reaches WIDTH-1.

## Structure
- Shared package calc_pkg:
  - op_e enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - state_e enum: IDLE, DIV, DONE.
- Sub-module div_restoring_step, parametrised by WIDTH. It is purely combinational: one restoring shift/subtract step, taking (partial remainder, quotient, divisor) and returning the next (remainder, quotient).
- seq_calculator holds the FSM, the operand registers, the counter and the output registers, and instantiates div_restoring_step once.

## Test plan
- Add, WIDTH=8: A=200, B=100, out_ready=1 -> result=0x012C, div_by_zero=0, out_valid exactly 1 cycle after accept.
- Sub: A=5, B=3 -> result=0xFFFE. Mul: A=255, B=255 -> result=0xFE01.
- Div: A=200, B=7 -> result=0x041C (remainder 4, quotient 28), out_valid 9 cycles after accept, in_ready=0 throughout.
- Div by zero: A=13, B=0 -> result=0x0DFF, div_by_zero=1, out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles after a mul result -> result stable, in_ready=0, and a concurrent in_valid is not accepted. Accept occurs only after the out_ready handshake.
- Reset mid-div: rst_n=0 for one edge at iteration 4 -> next cycle in_ready=1, out_valid=0, result=0. A following add of 1+1 returns 0x0002.
